// File: rtl/conv_maxpool2x2.sv
// rtl/conv_maxpool2x2.sv - 2x2 stride-2 max-pool stage behind the convolver datapath
// Optional fused ReLU on the pooled output: define POOL_RELU_EN.
module conv_maxpool2x2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_clear,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_row_last,
  output logic                         out_frame_last
);
  localparam int CONV_SIZE = IMAGE_SIZE - 2 * (KERNEL_SIZE / 2);
  localparam int POOL_SIZE = CONV_SIZE / 2;
  localparam int CW        = $clog2(CONV_SIZE);
  localparam logic [CW-1:0] LAST = CW'(CONV_SIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {FILL, EMIT} phase_t;

  phase_t                       state, state_next;
  logic [CW-1:0]                col, row;
  logic signed [DATA_WIDTH-1:0] pair;
  logic signed [DATA_WIDTH-1:0] line_buf [POOL_SIZE];
  logic                         accept, col_last, row_last;
  logic [CW-2:0]                lb_idx;
  logic signed [DATA_WIDTH-1:0] hmax, vmax, pooled;

  assign accept   = in_valid && !in_clear;
  assign col_last = (col == LAST);
  assign row_last = (row == LAST);
  assign lb_idx   = col[CW-1:1];

  always_comb begin
    hmax = (in_data > pair) ? in_data : pair;
    vmax = (line_buf[lb_idx] > hmax) ? line_buf[lb_idx] : hmax;
`ifdef POOL_RELU_EN
    pooled = vmax[DATA_WIDTH-1] ? '0 : vmax;
`else
    pooled = vmax;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Phase tracks row parity: flips on the last column of every row.
  always_comb begin
    state_next = state;
    if (in_clear)
      state_next = FILL;
    else if (accept && col_last)
      state_next = (state == FILL) ? EMIT : FILL;
  end

  // Line buffer carries no reset: every entry is written in FILL before EMIT reads it.
  always_ff @(posedge clk) begin
    if (accept && col[0] && state == FILL)
      line_buf[lb_idx] <= hmax;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col            <= '0;
      row            <= '0;
      pair           <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_row_last   <= 1'b0;
      out_frame_last <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_clear) begin
        col <= '0;
        row <= '0;
      end else if (in_valid) begin
        if (!col[0]) begin
          pair <= in_data;
        end else if (state == EMIT) begin
          out_valid      <= 1'b1;
          out_data       <= pooled;
          out_row_last   <= col_last;
          out_frame_last <= col_last && row_last;
        end
        col <= col_last ? '0 : col + ONE;
        if (col_last)
          row <= row_last ? '0 : row + ONE;
      end
    end
  end
endmodule

// File: tb/tb_conv_maxpool2x2.sv
// tb/tb_conv_maxpool2x2.sv - directed bench for conv_maxpool2x2 (24x24 -> 12x12)
// Covers ramp, negative, gapped, in_clear, async reset and back-to-back frames.
module tb_conv_maxpool2x2;
  localparam int CS = 24;
  localparam int PS = 12;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_clear;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_row_last;
  logic               out_frame_last;

  int errors = 0;
  int checks = 0;
  int br = 0, bc = 0;
  int pulse_err = 0;
  int got_d[$];
  int got_rl[$];
  int got_fl[$];

  conv_maxpool2x2 #(.DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_clear       (in_clear),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_row_last   (out_row_last),
    .out_frame_last (out_frame_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int data_of(input int kind, input int r, input int c);
    int pos, special;
    if (kind == 0) return r * CS + c;
    pos     = (r % 2) * 2 + (c % 2);
    special = ((r / 2) + (c / 2)) % 4;
    return (pos == special) ? -3 : -5;
  endfunction

  function automatic int exp_out(input int kind, input int pr, input int pc);
    int m, v;
    m = data_of(kind, 2 * pr, 2 * pc);
    for (int k = 1; k < 4; k++) begin
      v = data_of(kind, 2 * pr + k / 2, 2 * pc + k % 2);
      if (v > m) m = v;
    end
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic clear_q();
    got_d.delete();
    got_rl.delete();
    got_fl.delete();
    pulse_err = 0;
  endtask

  // One cycle: drive, clock, then verify the pulse appears exactly after odd/odd samples.
  task automatic send(input logic v, input int d);
    logic exp_pulse;
    in_valid  = v;
    in_data   = d[15:0];
    in_clear  = 1'b0;
    exp_pulse = v && (br % 2 == 1) && (bc % 2 == 1);
    @(posedge clk); #1;
    if (out_valid !== exp_pulse) pulse_err++;
    if (out_valid === 1'b1) begin
      got_d.push_back(int'($signed(out_data)));
      got_rl.push_back(int'(out_row_last));
      got_fl.push_back(int'(out_frame_last));
    end
    if (v) begin
      if (bc == CS - 1) begin
        bc = 0;
        br = (br == CS - 1) ? 0 : br + 1;
      end else begin
        bc++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int kind, input bit gapped);
    int sent = 0;
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CS; c++) begin
        send(1'b1, data_of(kind, r, c));
        sent++;
        if (gapped && sent % 25 == 0)
          repeat (5) send(1'b0, 0);
      end
  endtask

  task automatic check_frames(input string tag, input int kind, input int nframes);
    int mism = 0;
    int nfl = 0;
    int n;
    n = got_d.size();
    chk({tag, "_count"}, n, PS * PS * nframes);
    if (n > PS * PS * nframes) n = PS * PS * nframes;
    for (int i = 0; i < n; i++) begin
      int pr, pc;
      pr = (i % (PS * PS)) / PS;
      pc = i % PS;
      if (got_d[i] != exp_out(kind, pr, pc)) mism++;
      if (got_rl[i] != int'(pc == PS - 1)) mism++;
      if (got_fl[i] != int'(pr == PS - 1 && pc == PS - 1)) mism++;
      nfl += got_fl[i];
    end
    chk({tag, "_mismatches"}, mism, 0);
    chk({tag, "_frame_last_count"}, nfl, nframes);
    chk({tag, "_pulse_timing"}, pulse_err, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'($signed(out_data)), 0);
    chk("reset_row_last", int'(out_row_last), 0);
    chk("reset_frame_last", int'(out_frame_last), 0);

    // Continuous ramp frame
    clear_q();
    run_frame(0, 1'b0);
    check_frames("ramp", 0, 1);
    chk("ramp_first", got_d.size() > 0 ? got_d[0] : -1, 25);
    chk("ramp_first_row_last", got_d.size() > 11 ? got_d[11] : -1, 47);
    chk("ramp_row_last_flag", got_rl.size() > 11 ? got_rl[11] : -1, 1);
    chk("ramp_frame_last", got_d.size() > 143 ? got_d[143] : -1, 575);

    // All -5 with one -3 per window
    clear_q();
    run_frame(1, 1'b0);
    check_frames("neg", 1, 1);
`ifdef POOL_RELU_EN
    chk("neg_first", got_d.size() > 0 ? got_d[0] : -99, 0);
`else
    chk("neg_first", got_d.size() > 0 ? got_d[0] : -99, -3);
`endif

    // Gapped ramp: 25 on / 5 off
    clear_q();
    run_frame(0, 1'b1);
    check_frames("gap", 0, 1);
    chk("gap_first", got_d.size() > 0 ? got_d[0] : -1, 25);

    // in_clear with in_valid at row 7, col 10
    clear_q();
    for (int i = 0; i < 7 * CS + 10; i++)
      send(1'b1, data_of(0, i / CS, i % CS));
    in_valid = 1'b1;
    in_clear = 1'b1;
    in_data  = 16'sd999;
    @(posedge clk); #1;
    chk("clear_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    in_clear = 1'b0;
    br = 0;
    bc = 0;
    clear_q();
    run_frame(0, 1'b0);
    check_frames("clear", 0, 1);
    chk("clear_first", got_d.size() > 0 ? got_d[0] : -1, 25);

    // Async reset during EMIT row 3, right after the (3,5) pulse
    clear_q();
    for (int i = 0; i < 3 * CS + 6; i++)
      send(1'b1, data_of(0, i / CS, i % CS));
    chk("pre_reset_pulse", int'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", int'(out_valid), 0);
    chk("areset_out_data", int'($signed(out_data)), 0);
    chk("areset_row_last", int'(out_row_last), 0);
    @(negedge clk);
    reset = 1'b0;
    br = 0;
    bc = 0;
    clear_q();
    run_frame(0, 1'b0);
    check_frames("after_reset", 0, 1);

    // Two frames back-to-back, no idle cycle
    clear_q();
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    chk("b2b_count", got_d.size(), 2 * PS * PS);
    chk("b2b_frame1_last", got_fl.size() > 143 ? got_fl[143] : -1, 1);
    chk("b2b_frame1_last_data", got_d.size() > 143 ? got_d[143] : -1, 575);
    chk("b2b_frame2_first", got_d.size() > 144 ? got_d[144] : -99, exp_out(1, 0, 0));
    chk("b2b_frame2_last", got_fl.size() > 287 ? got_fl[287] : -1, 1);
    chk("b2b_pulse_timing", pulse_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_maxpool2x2.md
# conv_maxpool2x2

2x2 stride-2 max-pooling stage directly downstream of the convolver datapath. It consumes the convolver's output stream, qualified by the convolution enable strobe, and reduces each CONV_SIZE x CONV_SIZE feature map to POOL_SIZE x POOL_SIZE. It uses a half-row line buffer and pair register, and emits one pooled sample per completed 2x2 window to the next layer.

## Interface
- DATA_WIDTH, 16: width of signed convolution samples.
- IMAGE_SIZE, 28: input image edge length.
- KERNEL_SIZE, 5: convolution kernel edge length (odd).
- Derived CONV_SIZE = IMAGE_SIZE - 2*(KERNEL_SIZE/2) (24); POOL_SIZE = CONV_SIZE/2 (12). CONV_SIZE must be even.

Ports (clock and reset first):
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  convolution enable; in_data is a valid conv sample this cycle.
- in_data  input  DATA_WIDTH  signed two's-complement conv sample, raster order.
- in_clear  input  1  synchronous frame restart.
- out_valid  output  1  one-cycle pulse; out_data holds a pooled sample.
- out_data  output  DATA_WIDTH  signed pooled maximum.
- out_row_last  output  1  with out_valid: last sample of a pooled row.
- out_frame_last  output  1  with out_valid: last sample of the pooled frame.

## Operation
- Counters: col (0..CONV_SIZE-1) and row (0..CONV_SIZE-1) advance only on accepted samples (in_valid=1). Gaps of any length between samples are allowed.
- Phase FSM, 2 states:
  - FILL: even row.
  - EMIT: odd row.
  - FILL->EMIT on the accepted sample at col=CONV_SIZE-1 of an even row.
  - EMIT->FILL on the accepted sample at col=CONV_SIZE-1 of an odd row.
  - After row CONV_SIZE-1, col and row wrap to 0 and the next frame starts with no idle cycle required.
- Even col: sample stored in pair register.
- Odd col: hmax = max(pair, in_data), signed compare.
  - FILL: line_buf[col/2] <= hmax.
  - EMIT: out_data <= max(line_buf[col/2], hmax); out_valid pulses.
- Ties: the equal value is output (no ordering ambiguity).
- out_row_last = 1 when col=CONV_SIZE-1. out_frame_last = 1 additionally when row=CONV_SIZE-1.
- Each frame produces POOL_SIZE*POOL_SIZE out_valid pulses.
- in_clear:
  - Zeroes col, row, the FSM (to FILL) and out_valid on the next edge.
  - Has priority over a simultaneous in_valid; that sample is dropped.
  - line_buf is not cleared; it is always written in FILL before being read in EMIT.
- Reset mid-frame: same effect as in_clear, applied asynchronously. The partial frame is discarded.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_row_last=0, out_frame_last=0.
  - col=0, row=0, FSM=FILL, pair register=0.
  - line_buf contents are undefined.
- Latency: out_valid rises on the edge following the in_valid cycle of the odd-row, odd-col sample (1 cycle). It stays high exactly one cycle unless the next qualifying sample arrives back-to-back.
- out_data, out_row_last and out_frame_last are registered and valid only when out_valid=1. They hold their value otherwise.
- No backpressure: the downstream stage must accept every out_valid pulse.
- Throughput: one input sample per cycle sustained.

## Configuration
- POOL_RELU_EN:
  - Defined: out_data = max(pooled, 0); negative pooled results output as 0. Fused ReLU, no added latency.
  - Undefined: out_data is the raw signed maximum.

## Test plan
- Ramp frame: in_data = row*CONV_SIZE+col (24x24), continuous in_valid.
  - 144 pulses.
  - First out_data=25, first out_row_last data=47, out_frame_last data=575.
- Negative values: all samples -5 except one -3 per window.
  - Without POOL_RELU_EN every output = -3.
  - With POOL_RELU_EN every output = 0.
- Gapped input: in_valid pattern 25 on / 5 off, same ramp.
  - Output values and count identical to the continuous case.
  - Latency 1 cycle after each odd/odd sample.
- in_clear asserted with in_valid at row 7, col 10:
  - That sample is dropped.
  - A fresh ramp frame then yields first out_data=25 with no stale output.
- Async reset mid-EMIT row 3:
  - Outputs go to 0 immediately.
  - The following full frame produces exactly 144 pulses with correct values.
- Back-to-back frames (no idle):
  - out_frame_last exactly once per 576 samples.
  - The second frame's first output is correct.
